// File: rtl/led_frame_streamer.sv
// Frame buffer and sequencer feeding led_driver: holds one GRB frame, streams it
// over the ready/latched handshake, then holds the strip latch gap before frame_done.
module led_frame_streamer #(
    parameter int NUM_LEDS = 144,
    parameter int CLK_FREQ = 27000000,
    parameter int LATCH_US = 300,
    parameter int IDX_W    = $clog2(NUM_LEDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [23:0]      wr_data,
    input  logic             frame_start,
    output logic             frame_busy,
    output logic             frame_done,
    output logic             led_ready,
    output logic [23:0]      led_rgb,
    input  logic             led_data_latched,
    input  logic             led_busy
);

    localparam int LATCH_CYC = (CLK_FREQ / 1000000) * LATCH_US;
    localparam int GAP_W     = $clog2(LATCH_CYC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(LATCH_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        STREAM,
        DRAIN,
        GAP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic [GAP_W-1:0] gap_cnt;

    logic [23:0]      mem [NUM_LEDS];
    logic [23:0]      prefetch;
    logic             rd_en;
    logic [IDX_W-1:0] rd_addr;
    logic             advance;
    logic             wr_ok;

    assign wr_ok = wr_en && (int'(wr_addr) < NUM_LEDS);

    // RAM has no reset so the frame survives rst_n; the read register doubles
    // as the prefetch slot holding pixel idx+1 while idx is on led_rgb.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            prefetch <= mem[rd_addr];
        end
    end

    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        rd_addr    = '0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start && !frame_done) begin
                    state_next = FETCH;
                    rd_en      = 1'b1;
                end
            end
            FETCH: begin
                state_next = STREAM;
                rd_en      = 1'b1;
                rd_addr    = IDX_W'(1);
            end
            STREAM: begin
                if (led_data_latched) begin
                    if (idx == LAST_IDX) begin
                        state_next = DRAIN;
                    end else begin
                        advance = 1'b1;
                        if (int'(idx) + 2 < NUM_LEDS) begin
                            rd_en   = 1'b1;
                            rd_addr = idx + IDX_W'(2);
                        end
                    end
                end
            end
            DRAIN: begin
                if (!led_busy) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            gap_cnt    <= '0;
            frame_busy <= 1'b0;
            frame_done <= 1'b0;
            led_ready  <= 1'b0;
            led_rgb    <= '0;
        end else begin
            state      <= state_next;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (state_next == FETCH) begin
                        frame_busy <= 1'b1;
                        idx        <= '0;
                    end
                end
                FETCH: begin
                    led_rgb   <= prefetch;
                    led_ready <= 1'b1;
                end
                STREAM: begin
                    if (advance) begin
                        led_rgb <= prefetch;
                        idx     <= idx + IDX_W'(1);
                    end else if (state_next == DRAIN) begin
                        led_ready <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (state_next == GAP) begin
                        gap_cnt <= '0;
                    end
                end
                GAP: begin
                    if (state_next == IDLE) begin
                        frame_done <= 1'b1;
                        frame_busy <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_led_frame_streamer.sv
// Directed bench for led_frame_streamer: a modelled led_driver consumes frames
// while writes, stray frame_start pulses and a mid-frame reset are injected.
module tb_led_frame_streamer;

    localparam int N         = 144;
    localparam int LATCH_CYC = 8100;
    localparam int BUSY_HOLD = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [23:0] wr_data = '0;
    logic        frame_start = 1'b0;
    logic        led_data_latched = 1'b0;
    logic        led_busy = 1'b0;
    logic        frame_busy;
    logic        frame_done;
    logic        led_ready;
    logic [23:0] led_rgb;

    led_frame_streamer #(
        .NUM_LEDS(N),
        .CLK_FREQ(27000000),
        .LATCH_US(300)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .frame_start     (frame_start),
        .frame_busy      (frame_busy),
        .frame_done      (frame_done),
        .led_ready       (led_ready),
        .led_rgb         (led_rgb),
        .led_data_latched(led_data_latched),
        .led_busy        (led_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic [23:0] model     [N];
    logic [23:0] exp_frame [N];

    bit mid_writes = 0;
    bit start_poke = 0;
    bit bad_write  = 0;
    bit same_cycle = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic start_frame();
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        check("fetch_busy", frame_busy, 1);
        check("fetch_not_ready", led_ready, 0);
        @(negedge clk);
        check("first_word_ready", led_ready, 1);
    endtask

    // Driver model: latch one word every `spacing` cycles (spacing >= 4).
    task automatic stream_frame(input int spacing, input int reset_at);
        for (int k = 0; k < N; k++) begin
            if (k == reset_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_ready", led_ready, 0);
                check("rst_busy", frame_busy, 0);
                repeat (3) @(negedge clk);
                check("rst_rgb", led_rgb, 0);
                rst_n = 1'b1;
                repeat (20) begin
                    @(negedge clk);
                    if (frame_done) check("rst_no_done", frame_done, 0);
                end
                check("rst_idle_busy", frame_busy, 0);
                return;
            end
            @(negedge clk);
            if (mid_writes && k == 10) begin
                wr_en = 1'b1; wr_addr = 8'd5; wr_data = 24'hFF0000;
                model[5] = 24'hFF0000;
            end
            if (start_poke && k == 50) frame_start = 1'b1;
            @(negedge clk);
            wr_en = 1'b0; frame_start = 1'b0;
            if (mid_writes && k == 10) begin
                wr_en = 1'b1; wr_addr = 8'd100; wr_data = 24'h00FF00;
                model[100] = 24'h00FF00; exp_frame[100] = 24'h00FF00;
            end
            if (bad_write && k == 0) begin
                wr_en = 1'b1; wr_addr = 8'd150; wr_data = 24'h123456;
            end
            @(negedge clk);
            wr_en = 1'b0;
            repeat (spacing - 4) @(negedge clk);
            check($sformatf("word%0d", k), led_rgb, exp_frame[k]);
            check($sformatf("ready%0d", k), led_ready, 1);
            led_data_latched = 1'b1;
            if (k == N - 1) led_busy = 1'b1;
            if (same_cycle && k == 20) begin
                wr_en = 1'b1; wr_addr = 8'd22; wr_data = 24'hABCDEF;
                model[22] = 24'hABCDEF;
            end
            @(negedge clk);
            led_data_latched = 1'b0; wr_en = 1'b0;
        end
    endtask

    // Busy tail, latch gap, done timing; optionally restarts on the cycle after done.
    task automatic finish_frame(input bit restart);
        int cnt;
        check("ready_after_last", led_ready, 0);
        cnt = 1;
        while (!frame_done && cnt < 20000) begin
            if (cnt == BUSY_HOLD) led_busy = 1'b0;
            frame_start = (cnt == 1000);
            @(negedge clk);
            cnt++;
        end
        frame_start = 1'b0;
        check("done_delay", cnt, BUSY_HOLD + LATCH_CYC + 1);
        check("busy_at_done", frame_busy, 0);
        frame_start = 1'b1;
        @(negedge clk);
        check("done_one_cycle", frame_done, 0);
        check("start_on_done_ignored", frame_busy, 0);
        if (restart) begin
            @(negedge clk);
            frame_start = 1'b0;
            check("restart_busy", frame_busy, 1);
            check("restart_fetch", led_ready, 0);
            @(negedge clk);
            check("restart_ready", led_ready, 1);
        end else begin
            frame_start = 1'b0;
            repeat (3) @(negedge clk);
            check("no_restart", led_ready, 0);
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", led_ready, 0);
        check("reset_busy", frame_busy, 0);
        check("reset_done", frame_done, 0);
        check("reset_rgb", led_rgb, 0);
        rst_n = 1'b1;

        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = 8'(i); wr_data = 24'(i + 1);
            model[i] = 24'(i + 1);
        end
        @(negedge clk) wr_en = 1'b0;
        exp_frame = model;

        // Frame A: ramp data, mid-frame writes, stray start in STREAM and GAP.
        mid_writes = 1; start_poke = 1;
        start_frame();
        stream_frame(30, -1);
        finish_frame(1);

        // Frame B: already started; dropped write and same-cycle write/prefetch.
        mid_writes = 0; start_poke = 0; bad_write = 1; same_cycle = 1;
        exp_frame = model;
        stream_frame(5, -1);
        finish_frame(0);

        // Frame C: reset at idx 70.
        bad_write = 0; same_cycle = 0;
        exp_frame = model;
        start_frame();
        stream_frame(4, 70);

        // Frame D: full readback of retained RAM.
        exp_frame = model;
        start_frame();
        stream_frame(4, -1);
        finish_frame(0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
